decode_stage_pipe: RTL
======================

# decode_stage_pipe

Parametrised, pipelined decode stage for the RV32I core. It holds the integer register file and a writeback-to-decode bypass. It also keeps a scoreboard that stalls on RAW/WAW hazards. It produces ALU op, operands, rd and immediate into a single output register with a valid/ready handshake, and sits between fetch and execute, replacing the combinational decode.

## Interface
- XLEN, 32: data width (≥32); immediates sign-extended to XLEN
- NREGS, 32: architectural registers (16 or 32); addresses ≥ NREGS read 0, ignore writes, never busy

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents instr
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  instruction word
- wb_en  in  1  writeback strobe
- wb_addr  in  5  writeback register
- wb_data  in  XLEN  writeback value
- csr_load  in  1  load csr from wb_data
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- alu_op  out  4  ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10, NOP 15
- rs1_data, rs2_data  out  XLEN  operands
- rd_addr  out  5  destination (0 if no rd write)
- imm  out  XLEN  I/S/B/U/J immediate, 0 for R-type
- csr  out  XLEN  csr register

## Operation
- Classes: writes-rd = OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR with rd≠0. Reads-rs1 = OP, OP-IMM, LOAD, STORE, BRANCH, JALR. Reads-rs2 = OP, STORE, BRANCH.
- ALU op: OP/OP-IMM from funct3; instr[30] selects SUB (OP only) and SRA. LUI gives PASSB. LOAD/STORE/AUIPC/JAL/JALR give ADD. BRANCH gives SUB. Unknown opcode gives NOP with rd_addr=0.
- Register read: x0 reads 0. If wb_en and wb_addr equals the source (nonzero, <NREGS), the value is wb_data (bypass). Otherwise the value is the stored register.
- Register write: on wb_en with wb_addr≠0 and <NREGS. A write to x0 is ignored.
- Scoreboard: busy[NREGS] bits.
  - set busy[rd] on accept of a writes-rd instruction.
  - clear busy[wb_addr] on wb_en.
  - Same register set and cleared in one cycle: set wins.
- hazard = (a read source is busy and not cleared this cycle) OR (rd is busy and not cleared this cycle).
- in_ready = ~hazard & (~out_valid | out_ready). accept = in_valid & in_ready.
- Output register:
  - On accept, load the bundle and set out_valid.
  - On out_ready with no accept, clear out_valid.
  - With out_valid=1 and out_ready=0, the bundle is held stable.
- csr loads wb_data on csr_load, independent of wb_en.

## Timing
- Latency: instr accepted in cycle N gives its bundle at out_valid in cycle N+1.
- Throughput: 1/cycle when hazard-free and out_ready=1.
- Reset (reset=0, asynchronous): all registers 0, busy all 0, out_valid 0, csr 0, all bundle outputs 0. in_ready=0 while reset is asserted.
- Reset mid-operation discards any held bundle and all busy bits.
- in_ready is combinational from in_valid-independent state, instr, wb_*, out_ready. It does not depend on in_valid.

## Configuration
- DECODE_BYPASS_EN defined: same-cycle wb_data bypass as above; a busy source clears hazard in its wb cycle.
- DECODE_BYPASS_EN undefined: no bypass; reads return stored values. A source matching wb_addr under wb_en is still hazardous, so the instruction issues one cycle after writeback. Busy clearing is unchanged.

## Test plan
- Reset then accept `addi x1,x0,5` (0x00500093) with out_ready=1. Cycle+1 bundle: alu_op=0, rs1_data=0, imm=5, rd_addr=1, out_valid=1, busy[1]=1.
- RAW: `add x2,x1,x1` follows while busy[1]=1. in_ready=0 until wb_en, wb_addr=1, wb_data=5.
  - Bypass build: accept in the wb cycle, rs1_data=rs2_data=5.
  - Non-bypass build: accept one cycle later.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1. The bundle is held stable, in_ready=0, and no second accept occurs.
- Writes to x0 and to x20 with NREGS=16 are ignored. Reads of them return 0; `addi x0,x0,1` gives rd_addr=0 and sets no busy bit.
- Set and clear of the same register in one cycle: wb x3 while accepting `lui x3,0x12345` (0x123451b7). busy[3]=1 after, imm=0x12345000, alu_op=10.
- Assert reset with out_valid=1 and busy[1]=1. Outputs go to 0 immediately and csr=0. After release, `sub x4,x1,x2` gives alu_op=1 and is not stalled.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: register file, scoreboard stall on RAW/WAW, one-cycle latency into a valid/ready
// output register that holds while out_ready=0. Define DECODE_BYPASS_EN for same-cycle writeback bypass.
module decode_stage_pipe #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            csr_load,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_op,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] csr
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;
   localparam logic [3:0] ALU_NOP   = 4'd15;

   localparam logic [5:0] NREGS_W = 6'(NREGS);

   function automatic logic addr_ok(input logic [4:0] a);
      return (a != 5'd0) && ({1'b0, a} < NREGS_W);
   endfunction

   function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt, input logic is_op);
      logic [3:0] r;
      case (f3)
         3'd0:    r = (alt && is_op) ? ALU_SUB : ALU_ADD;
         3'd1:    r = ALU_SLL;
         3'd2:    r = ALU_SLT;
         3'd3:    r = ALU_SLTU;
         3'd4:    r = ALU_XOR;
         3'd5:    r = alt ? ALU_SRA : ALU_SRL;
         3'd6:    r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   logic [XLEN-1:0]  csr_q, csr_d;
   logic [4:0]       rd_addr_q, rd_addr_d;

   logic [6:0]      opcode;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      f3;
   logic            wr_rd, use_rs1, use_rs2;
   logic [3:0]      dec_op;
   logic [XLEN-1:0] dec_imm;
   logic [4:0]      dec_rd;
   logic [XLEN-1:0] src1_val, src2_val;
   logic            busy1, busy2, busyd;
   logic            wb_hit1, wb_hit2, wb_hitd;
   logic            haz1, haz2, hazd, hazard, accept;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign f3     = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   always_comb begin : decode
      dec_op  = ALU_NOP;
      dec_imm = '0;
      wr_rd   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_op = f3_op(f3, instr[30], 1'b1);
            wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OPC_OPIMM: begin
            dec_op  = f3_op(f3, instr[30], 1'b0);
            dec_imm = XLEN'($signed(instr[31:20]));
            wr_rd = 1'b1; use_rs1 = 1'b1;
         end
         OPC_LOAD, OPC_JALR: begin
            dec_op  = ALU_ADD;
            dec_imm = XLEN'($signed(instr[31:20]));
            wr_rd = 1'b1; use_rs1 = 1'b1;
         end
         OPC_STORE: begin
            dec_op  = ALU_ADD;
            dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OPC_BRANCH: begin
            dec_op  = ALU_SUB;
            dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_op  = (opcode == OPC_LUI) ? ALU_PASSB : ALU_ADD;
            dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
            wr_rd = 1'b1;
         end
         OPC_JAL: begin
            dec_op  = ALU_ADD;
            dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            wr_rd = 1'b1;
         end
         default: ;
      endcase
      dec_rd = (wr_rd && rd != 5'd0) ? rd : 5'd0;
   end

   // Out-of-range addresses fall outside the loops, so they read 0 and are never busy.
   always_comb begin : sb_and_read
      busy1    = 1'b0;
      busy2    = 1'b0;
      busyd    = 1'b0;
      src1_val = '0;
      src2_val = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (rs1 == 5'(i)) begin
            busy1    = busy_q[i];
            src1_val = regs_q[i];
         end
         if (rs2 == 5'(i)) begin
            busy2    = busy_q[i];
            src2_val = regs_q[i];
         end
         if (dec_rd == 5'(i)) busyd = busy_q[i];
      end
      wb_hit1 = wb_en && (wb_addr == rs1) && addr_ok(rs1);
      wb_hit2 = wb_en && (wb_addr == rs2) && addr_ok(rs2);
      wb_hitd = wb_en && (wb_addr == dec_rd);
`ifdef DECODE_BYPASS_EN
      if (wb_hit1) src1_val = wb_data;
      if (wb_hit2) src2_val = wb_data;
      haz1 = use_rs1 && busy1 && !wb_hit1;
      haz2 = use_rs2 && busy2 && !wb_hit2;
`else
      haz1 = use_rs1 && (busy1 || wb_hit1);
      haz2 = use_rs2 && (busy2 || wb_hit2);
`endif
      if (!use_rs1) src1_val = '0;
      if (!use_rs2) src2_val = '0;
      hazd   = busyd && !wb_hitd;
      hazard = haz1 || haz2 || hazd;
   end

   assign in_ready = reset && !hazard && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin : next_state
      regs_d = regs_q;
      busy_d = busy_q;
      for (int i = 1; i < NREGS; i++) begin
         if (wb_en && wb_addr == 5'(i)) begin
            regs_d[i] = wb_data;
            busy_d[i] = 1'b0;
         end
      end
      // Applied after the clear so a same-cycle set wins.
      for (int i = 1; i < NREGS; i++) begin
         if (accept && dec_rd == 5'(i)) busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
      csr_d = csr_load ? wb_data : csr_q;

      out_valid_d = out_valid_q;
      alu_op_d    = alu_op_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      rd_addr_d   = rd_addr_q;
      imm_d       = imm_q;
      if (accept) begin
         out_valid_d = 1'b1;
         alu_op_d    = dec_op;
         rs1_data_d  = src1_val;
         rs2_data_d  = src2_val;
         rd_addr_d   = dec_rd;
         imm_d       = dec_imm;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         busy_q      <= '0;
         csr_q       <= '0;
         out_valid_q <= 1'b0;
         alu_op_q    <= 4'd0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         rd_addr_q   <= 5'd0;
         imm_q       <= '0;
      end else begin
         regs_q      <= regs_d;
         busy_q      <= busy_d;
         csr_q       <= csr_d;
         out_valid_q <= out_valid_d;
         alu_op_q    <= alu_op_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         rd_addr_q   <= rd_addr_d;
         imm_q       <= imm_d;
      end
   end

   assign out_valid = out_valid_q;
   assign alu_op    = alu_op_q;
   assign rs1_data  = rs1_data_q;
   assign rs2_data  = rs2_data_q;
   assign rd_addr   = rd_addr_q;
   assign imm       = imm_q;
   assign csr       = csr_q;

endmodule
